// File: rtl/tmds_pkg.sv
// Shared TMDS definitions for the lane encoder and decoder: symbol width,
// the four control tokens, the CD-to-token mapping and the decoder's
// alignment FSM state type.
package tmds_pkg;

  localparam int SYM_W = 10;

  // Control tokens, written bit 9 .. bit 0 (bit 0 is serialized first).
  localparam logic [SYM_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

  // Symbol alignment FSM of the decoder.
  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_LOCKED = 2'd2
  } align_state_e;

  // Control data value to the token transmitted for it.
  function automatic logic [SYM_W-1:0] cd_to_token(input logic [1:0] cd);
    logic [SYM_W-1:0] tok;
    case (cd)
      2'b00:   tok = CTRL_TOKEN_00;
      2'b01:   tok = CTRL_TOKEN_01;
      2'b10:   tok = CTRL_TOKEN_10;
      default: tok = CTRL_TOKEN_11;
    endcase
    return tok;
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational 10b symbol classifier/decoder: flags control tokens with
// their CD value, and undoes the encoder's inversion and XOR/XNOR chain
// for data symbols.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [SYM_W-1:0] i_sym,
  output logic             o_is_ctrl,
  output logic [1:0]       o_cd,
  output logic [7:0]       o_vd
);

  logic [7:0] w_d;

  // Token match against the shared CD-to-token table.
  always_comb begin
    o_is_ctrl = 1'b0;
    o_cd      = 2'b00;
    for (int k = 0; k < 4; k++) begin
      if (i_sym == cd_to_token(2'(k))) begin
        o_is_ctrl = 1'b1;
        o_cd      = 2'(k);
      end
    end
  end

  // Data decode: bit 9 undoes inversion, bit 8 selects XOR (1) or XNOR (0).
  always_comb begin
    w_d     = i_sym[9] ? ~i_sym[7:0] : i_sym[7:0];
    o_vd    = '0;
    o_vd[0] = w_d[0];
    for (int i = 1; i < 8; i++) begin
      o_vd[i] = w_d[i] ^ w_d[i-1] ^ ~i_sym[8];
    end
  end

endmodule

// File: rtl/tmds_decoder.sv
// One TMDS sink lane: symbol alignment by bitslip requests, two-stage
// decode pipeline (stage 1 registers the classified symbol, stage 2 the
// decoded outputs), and output gating while alignment is not locked.
// Optional running-disparity checker enabled by TMDS_DECODER_DISPARITY_CHECK_EN.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT    = 8,
  parameter int SEARCH_WINDOW = 1024,
  parameter int SLIP_WAIT     = 4,
  parameter int LOSS_WINDOW   = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SYM_W-1:0] tmds_in,
  output logic [7:0]       vd,
  output logic [1:0]       cd,
  output logic             vde,
  output logic             locked,
  output logic             bitslip,
  output logic             err
);

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W  = $clog2(SEARCH_WINDOW + 1);
  localparam int SLIP_W = $clog2(SLIP_WAIT + 1);
  localparam int LOSS_W = $clog2(LOSS_WINDOW + 1);

  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
  localparam logic [WIN_W-1:0]  WIN_MAX   = WIN_W'(SEARCH_WINDOW);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [SLIP_W-1:0] SLIP_MAX  = SLIP_W'(SLIP_WAIT);
  localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(SLIP_WAIT - 1);
  localparam logic [LOSS_W-1:0] LOSS_MAX  = LOSS_W'(LOSS_WINDOW);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_WINDOW - 1);

  // Classification of the incoming symbol (drives FSM and stage 1).
  logic       w_is_ctrl;
  logic [1:0] w_cd;
  logic [7:0] w_vd;

  tmds_symbol_decode u_symbol_decode (
    .i_sym     (tmds_in),
    .o_is_ctrl (w_is_ctrl),
    .o_cd      (w_cd),
    .o_vd      (w_vd)
  );

  // Alignment FSM state and counters; r_state is the observable FSM state.
  align_state_e      r_state, w_state_nxt;
  logic [RUN_W-1:0]  r_run,   w_run_nxt;
  logic [WIN_W-1:0]  r_win,   w_win_nxt;
  logic [SLIP_W-1:0] r_slip,  w_slip_nxt;
  logic [LOSS_W-1:0] r_loss,  w_loss_nxt;
  logic              w_bitslip_nxt;
  logic              r_locked;
  logic              r_bitslip;

  // Pipeline registers.
  logic       r_s1_is_ctrl;
  logic [1:0] r_s1_cd;
  logic [7:0] r_s1_vd;
  logic       r_s1_err;
  logic       r_vde;
  logic [7:0] r_vd;
  logic [1:0] r_cd;
  logic       r_err;

  // FSM state and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_SEARCH;
      r_run     <= '0;
      r_win     <= '0;
      r_slip    <= '0;
      r_loss    <= '0;
      r_locked  <= 1'b0;
      r_bitslip <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_run     <= w_run_nxt;
      r_win     <= w_win_nxt;
      r_slip    <= w_slip_nxt;
      r_loss    <= w_loss_nxt;
      r_locked  <= (w_state_nxt == ST_LOCKED);
      r_bitslip <= w_bitslip_nxt;
    end
  end

  // Next state and counter updates; lock takes priority over a slip request.
  always_comb begin
    w_state_nxt   = r_state;
    w_run_nxt     = r_run;
    w_win_nxt     = r_win;
    w_slip_nxt    = r_slip;
    w_loss_nxt    = r_loss;
    w_bitslip_nxt = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        if (w_is_ctrl) begin
          w_run_nxt = (r_run == RUN_MAX) ? r_run : r_run + 1'b1;
        end else begin
          w_run_nxt = '0;
        end
        w_win_nxt = (r_win == WIN_MAX) ? r_win : r_win + 1'b1;
        if (w_is_ctrl && (r_run >= RUN_LAST)) begin
          w_state_nxt = ST_LOCKED;
          w_run_nxt   = '0;
          w_win_nxt   = '0;
          w_loss_nxt  = '0;
        end else if (r_win >= WIN_LAST) begin
          w_state_nxt   = ST_SLIP;
          w_bitslip_nxt = 1'b1;
          w_run_nxt     = '0;
          w_win_nxt     = '0;
          w_slip_nxt    = '0;
        end
      end
      ST_SLIP: begin
        // Input is ignored while the deserializer settles.
        w_run_nxt = '0;
        w_win_nxt = '0;
        if (r_slip >= SLIP_LAST) begin
          w_state_nxt = ST_SEARCH;
          w_slip_nxt  = '0;
        end else begin
          w_slip_nxt = (r_slip == SLIP_MAX) ? r_slip : r_slip + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (w_is_ctrl) begin
          w_loss_nxt = '0;
        end else if (r_loss >= LOSS_LAST) begin
          // Too long without a control token: realign, but without a slip.
          w_state_nxt = ST_SEARCH;
          w_loss_nxt  = '0;
          w_run_nxt   = '0;
          w_win_nxt   = '0;
        end else begin
          w_loss_nxt = (r_loss == LOSS_MAX) ? r_loss : r_loss + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_SEARCH;
      end
    endcase
  end

`ifdef TMDS_DECODER_DISPARITY_CHECK_EN
  // Running disparity of the link, tracked exactly like the encoder.
  logic signed [5:0] r_disp;
  logic        [7:0] w_qm;
  logic        [3:0] w_n1;
  logic signed [5:0] w_diff;
  logic signed [5:0] w_delta;
  logic              w_exp9;

  // Recover q_m, then repeat the encoder's invert decision and count update.
  always_comb begin
    w_qm = tmds_in[9] ? ~tmds_in[7:0] : tmds_in[7:0];
    w_n1 = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_n1 = w_n1 + {3'd0, w_qm[i]};
    end
    w_diff  = $signed({1'b0, w_n1, 1'b0}) - 6'sd8;
    w_exp9  = 1'b0;
    w_delta = '0;
    if ((r_disp == 6'sd0) || (w_n1 == 4'd4)) begin
      w_exp9  = ~tmds_in[8];
      w_delta = tmds_in[8] ? w_diff : -w_diff;
    end else if (((r_disp > 6'sd0) && (w_n1 > 4'd4)) ||
                 ((r_disp < 6'sd0) && (w_n1 < 4'd4))) begin
      w_exp9  = 1'b1;
      w_delta = (tmds_in[8] ? 6'sd2 : 6'sd0) - w_diff;
    end else begin
      w_exp9  = 1'b0;
      w_delta = w_diff - (tmds_in[8] ? 6'sd0 : 6'sd2);
    end
  end

  // Disparity register and stage-1 error flag; tokens reset the disparity.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp   <= '0;
      r_s1_err <= 1'b0;
    end else if (w_is_ctrl) begin
      r_disp   <= '0;
      r_s1_err <= 1'b0;
    end else begin
      r_disp   <= r_disp + w_delta;
      r_s1_err <= (tmds_in[9] != w_exp9);
    end
  end

  assign err = r_err & r_locked;
`else
  // No disparity tracking in this build.
  always_ff @(posedge clk) begin
    r_s1_err <= 1'b0;
  end

  assign err = 1'b0;
`endif

  // Stage 1: register the classified symbol.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_is_ctrl <= 1'b0;
      r_s1_cd      <= '0;
      r_s1_vd      <= '0;
    end else begin
      r_s1_is_ctrl <= w_is_ctrl;
      r_s1_cd      <= w_cd;
      r_s1_vd      <= w_vd;
    end
  end

  // Stage 2: decoded outputs; cd holds the last control value in data periods.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vde <= 1'b0;
      r_vd  <= '0;
      r_cd  <= '0;
      r_err <= 1'b0;
    end else begin
      r_vde <= ~r_s1_is_ctrl;
      r_vd  <= r_s1_is_ctrl ? 8'h00 : r_s1_vd;
      r_err <= r_s1_err;
      if (r_s1_is_ctrl) begin
        r_cd <= r_s1_cd;
      end
    end
  end

  // Outputs are forced to 0 whenever alignment is not locked.
  assign vde     = r_vde & r_locked;
  assign vd      = r_locked ? r_vd : 8'h00;
  assign cd      = r_locked ? r_cd : 2'b00;
  assign locked  = r_locked;
  assign bitslip = r_bitslip;

endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: directed symbol streams, a due-cycle scoreboard
// checked by an independent monitor, and direct checks of lock/slip timing.
module tb_tmds_decoder;

  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK1 = 10'b0010101011;
  localparam logic [9:0] TOK2 = 10'b0101010100;
  localparam logic [9:0] TOK3 = 10'b1010101011;
  // TOK0 rotated left by 3 bits: what a misaligned deserializer delivers.
  localparam logic [9:0] ROT  = 10'b1010100110;

`ifdef TMDS_DECODER_DISPARITY_CHECK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  // Scoreboard word: {due cycle[31:0], tag[7:0], vde, vd[7:0], cd[1:0], err}.
  localparam int EW = 52;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] tmds_in = '0;
  logic [7:0] vd;
  logic [1:0] cd;
  logic       vde;
  logic       locked;
  logic       bitslip;
  logic       err;

  logic [EW-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int enc_cnt = 0;
  int n_slip_seen = 0;

  tmds_decoder dut (
    .clk     (clk),
    .rst     (rst),
    .tmds_in (tmds_in),
    .vd      (vd),
    .cd      (cd),
    .vde     (vde),
    .locked  (locked),
    .bitslip (bitslip),
    .err     (err)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic string tag_name(input int t);
    case (t)
      1: return "sb_tokens";
      2: return "sb_ramp";
      3: return "sb_pre_rst";
      4: return "sb_disparity";
      5: return "sb_loss";
      default: return "sb_other";
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor: pops every expectation that falls due this cycle.
  logic [EW-1:0] mon_e;
  logic [11:0]   mon_act;
  int            mon_due;
  always @(negedge clk) begin
    if (bitslip) n_slip_seen++;
    while (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) <= cyc) begin
      mon_e   = exp_q.pop_front();
      mon_due = int'(mon_e[EW-1 -: 32]);
      mon_act = {vde, vd, cd, err};
      n_cmp++;
      if (mon_due != cyc || mon_act !== mon_e[11:0]) begin
        n_fail++;
        $display("FAIL %s: got vde=%0b vd=0x%02h cd=%0d err=%0b required vde=%0b vd=0x%02h cd=%0d err=%0b (due %0d, cycle %0d)",
                 tag_name(int'(mon_e[19:12])), vde, vd, cd, err,
                 mon_e[11], mon_e[10:3], mon_e[2:1], mon_e[0], mon_due, cyc);
      end
    end
  end

  // Driver: one symbol per cycle; expected outputs fall due 2 edges later.
  task automatic send(input logic [9:0] sym, input logic push, input logic vde_e,
                      input logic [7:0] vd_e, input logic [1:0] cd_e,
                      input logic err_e, input int tag);
    @(negedge clk);
    tmds_in = sym;
    if (push) exp_q.push_back({32'(cyc + 2), 8'(tag), vde_e, vd_e, cd_e, err_e});
  endtask

  // Reference DVI TMDS encoder for video data (stimulus generation).
  task automatic encode(input logic [7:0] d, output logic [9:0] s);
    logic [8:0] qm;
    int n1d, n1, n0;
    n1d   = $countones(d);
    qm    = '0;
    qm[0] = d[0];
    if (n1d > 4 || (n1d == 4 && !d[0])) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (enc_cnt == 0 || n1 == n0) begin
      s = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      enc_cnt += qm[8] ? (n1 - n0) : (n0 - n1);
    end else if ((enc_cnt > 0 && n1 > n0) || (enc_cnt < 0 && n0 > n1)) begin
      s = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt += 2 * int'(qm[8]) + n0 - n1;
    end else begin
      s = {1'b0, qm[8], qm[7:0]};
      enc_cnt += -2 * int'(!qm[8]) + n1 - n0;
    end
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_locked"},  32'(locked),  32'd0);
    chk({pfx, "_bitslip"}, 32'(bitslip), 32'd0);
    chk({pfx, "_vde"},     32'(vde),     32'd0);
    chk({pfx, "_vd"},      32'(vd),      32'd0);
    chk({pfx, "_cd"},      32'(cd),      32'd0);
    chk({pfx, "_err"},     32'(err),     32'd0);
  endtask

  logic [9:0] sym;
  logic [7:0] b;
  logic       le;
  int rst_cyc, n_slips, lock_cyc, slip_snap;
  int p[3];

  initial begin
    // Reset.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");

    // Lock on 8 tokens; locked rises on the 9th cycle.
    for (int k = 1; k <= 8; k++) send(TOK0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1);
    chk("lock_before_8th_sampled", 32'(locked), 32'd0);
    send(TOK0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1);
    chk("lock_9th_cycle", 32'(locked), 32'd1);
    send(TOK1, 1'b1, 1'b0, 8'h00, 2'b01, 1'b0, 1);
    send(TOK2, 1'b1, 1'b0, 8'h00, 2'b10, 1'b0, 1);
    send(TOK3, 1'b1, 1'b0, 8'h00, 2'b11, 1'b0, 1);
    chk("no_slip_when_locked", 32'(bitslip), 32'd0);

    // Full data ramp; cd holds 11 from the last token.
    enc_cnt = 0;
    for (int v = 0; v < 256; v++) begin
      encode(8'(v), sym);
      send(sym, 1'b1, 1'b1, 8'(v), 2'b11, 1'b0, 2);
    end
    send(TOK0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 2);

    // Reset while streaming data.
    enc_cnt = 0;
    for (int v = 0; v < 4; v++) begin
      b = 8'hA5 + 8'(v * 17);
      encode(b, sym);
      send(sym, 1'b1, 1'b1, b, 2'b00, 1'b0, 3);
    end
    for (int v = 0; v < 2; v++) begin
      encode(8'h33, sym);
      send(sym, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 3);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rst_cyc = cyc;
    check_all_zero("mid_rst");

    // Misaligned stream: slips until the 3rd, then correct tokens.
    n_slips  = 0;
    lock_cyc = -1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (bitslip) begin
        if (n_slips < 3) p[n_slips] = cyc;
        n_slips++;
      end
      if (locked && n_slips >= 3) begin
        lock_cyc = cyc;
        break;
      end
      tmds_in = (n_slips >= 3) ? TOK0 : ROT;
    end
    chk("slip_count", 32'(n_slips), 32'd3);
    chk("slip1_after_rst", 32'(p[0] - rst_cyc), 32'd1024);
    chk("slip_period_1_2", 32'(p[1] - p[0]), 32'd1028);
    chk("slip_period_2_3", 32'(p[2] - p[1]), 32'd1028);
    chk("relock_delay", 32'(lock_cyc - p[2]), 32'd12);

    // Disparity: bit 9 of encoded 0x00 (0x100 at zero disparity) flipped.
    send(TOK0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 4);
    send(10'h300, 1'b1, 1'b1, 8'h01, 2'b00, ERR_ON, 4);
    send(TOK0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 4);
    enc_cnt = 0;
    encode(8'h3C, sym);
    send(sym, 1'b1, 1'b1, 8'h3C, 2'b00, 1'b0, 4);
    send(TOK0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 4);

    // Loss of lock after LOSS_WINDOW data symbols without a token.
    send(TOK2, 1'b1, 1'b0, 8'h00, 2'b10, 1'b0, 5);
    slip_snap = n_slip_seen;
    enc_cnt = 0;
    for (int j = 1; j <= 2048; j++) begin
      b  = 8'(j) ^ 8'h5A;
      le = (j <= 2046);
      encode(b, sym);
      send(sym, 1'b1, le, le ? b : 8'h00, le ? 2'b10 : 2'b00, 1'b0, 5);
    end
    chk("loss_still_locked", 32'(locked), 32'd1);
    for (int j = 0; j < 4; j++) begin
      encode(8'(j), sym);
      send(sym, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 5);
      if (j == 0) chk("loss_unlocked", 32'(locked), 32'd0);
    end
    repeat (3) @(negedge clk);
    chk("loss_no_bitslip", 32'(n_slip_seen - slip_snap), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
